// File: rtl/mem_port_arbiter.sv
// Two-client round-robin arbiter in front of a single-port RAM with a 1-cycle registered read.
// One access in flight at a time; addresses at or beyond MEMORY_QTY complete with err and no RAM access.
module mem_port_arbiter #(
   parameter int WORD_SIZE    = 8,
   parameter int ADDRESS_SIZE = 4,
   parameter int MEMORY_QTY   = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                req,
   input  logic [1:0]                we,
   input  logic [2*ADDRESS_SIZE-1:0] addr,
   input  logic [2*WORD_SIZE-1:0]    wdata,
   output logic [1:0]                ack,
   output logic [1:0]                err,
   output logic [WORD_SIZE-1:0]      rdata,
   output logic                      busy,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDRESS_SIZE-1:0]   mem_addr,
   output logic [WORD_SIZE-1:0]      mem_wdata,
   input  logic [WORD_SIZE-1:0]      mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                  state_reg, state_next;
   logic                    grant_reg, grant_next;
   logic                    last_grant_reg, last_grant_next;
   logic                    we_reg, we_next;
   logic                    fault_reg, fault_next;
   logic [1:0]              ack_reg, ack_next;
   logic [1:0]              err_reg, err_next;
   logic [WORD_SIZE-1:0]    rdata_reg, rdata_next;
   logic                    busy_reg, busy_next;
   logic                    mem_en_reg, mem_en_next;
   logic                    mem_we_reg, mem_we_next;
   logic [ADDRESS_SIZE-1:0] mem_addr_reg, mem_addr_next;
   logic [WORD_SIZE-1:0]    mem_wdata_reg, mem_wdata_next;
   logic                    grant_sel;

   logic [ADDRESS_SIZE-1:0] client_addr     [2];
   logic [WORD_SIZE-1:0]    client_wdata    [2];
   logic                    client_in_range [2];

   // Range check is done at grant time so mem_en can be a plain register in ISSUE.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_client
         assign client_addr[gi]     = addr[gi*ADDRESS_SIZE +: ADDRESS_SIZE];
         assign client_wdata[gi]    = wdata[gi*WORD_SIZE +: WORD_SIZE];
         assign client_in_range[gi] = (32'(client_addr[gi]) < MEMORY_QTY);
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         we_reg         <= 1'b0;
         fault_reg      <= 1'b0;
         ack_reg        <= '0;
         err_reg        <= '0;
         rdata_reg      <= '0;
         busy_reg       <= 1'b0;
         mem_en_reg     <= 1'b0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         we_reg         <= we_next;
         fault_reg      <= fault_next;
         ack_reg        <= ack_next;
         err_reg        <= err_next;
         rdata_reg      <= rdata_next;
         busy_reg       <= busy_next;
         mem_en_reg     <= mem_en_next;
         mem_we_reg     <= mem_we_next;
         mem_addr_reg   <= mem_addr_next;
         mem_wdata_reg  <= mem_wdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      we_next         = we_reg;
      fault_next      = fault_reg;
      ack_next        = '0;
      err_next        = '0;
      rdata_next      = rdata_reg;
      mem_en_next     = 1'b0;
      mem_we_next     = 1'b0;
      mem_addr_next   = mem_addr_reg;
      mem_wdata_next  = mem_wdata_reg;
      grant_sel       = ~last_grant_reg;

      case (state_reg)
         IDLE: begin
            if (req != 2'b00) begin
               // On a tie the client that did not win last time goes first.
               if (req == 2'b11) grant_sel = ~last_grant_reg;
               else              grant_sel = req[1];
               grant_next      = grant_sel;
               last_grant_next = grant_sel;
               we_next         = we[grant_sel];
               fault_next      = ~client_in_range[grant_sel];
               if (client_in_range[grant_sel]) begin
                  mem_en_next    = 1'b1;
                  mem_we_next    = we[grant_sel];
                  mem_addr_next  = client_addr[grant_sel];
                  mem_wdata_next = client_wdata[grant_sel];
               end
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            if (fault_reg || we_reg) begin
               ack_next[grant_reg] = 1'b1;
               err_next[grant_reg] = fault_reg;
               state_next          = DONE;
            end else begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            rdata_next          = mem_rdata;
            ack_next[grant_reg] = 1'b1;
            state_next          = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

   assign ack       = ack_reg;
   assign err       = err_reg;
   assign rdata     = rdata_reg;
   assign busy      = busy_reg;
   assign mem_en    = mem_en_reg;
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every cycle,
// directed handshake/fairness/range/reset cases, then randomized two-client traffic.
module tb_mem_port_arbiter;

   localparam int QTY = 10;

   logic       clock;
   logic       reset;
   logic       req0, req1, we0, we1;
   logic [3:0] a0, a1;
   logic [7:0] d0, d1;
   logic [1:0] req, we;
   logic [7:0] addr;
   logic [15:0] wdata;
   logic [1:0] ack, err;
   logic [7:0] rdata;
   logic       busy, mem_en, mem_we;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   assign req   = {req1, req0};
   assign we    = {we1, we0};
   assign addr  = {a1, a0};
   assign wdata = {d1, d0};

   mem_port_arbiter #(.WORD_SIZE(8), .ADDRESS_SIZE(4), .MEMORY_QTY(QTY)) dut (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // The shared RAM: single port, registered read.
   logic [7:0] ram [16];
   logic [7:0] ram_q;
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected outputs per cycle, scheduled when a transaction is granted.
   typedef struct {
      logic       busy;
      logic       mem_en;
      logic       mem_we;
      logic [3:0] a;
      logic [7:0] d;
      logic [1:0] ack;
      logic [1:0] err;
      logic       rd_upd;
      logic [7:0] rd_val;
   } slot_t;

   slot_t      slot [8];
   logic [7:0] exp_mem [16];
   logic [7:0] exp_rdata;
   int         free_at;
   int         last;
   int         cyc;
   int         checks;
   int         errors;
   int         mem_en_cnt;
   int         ack_log [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 8; i++) slot[i] = '{default: '0};
      free_at   = 0;
      last      = 1;
      exp_rdata = 8'h00;
   endtask

   // An access granted off the IDLE cycle n occupies n+1 (RAM strobe), then ends with
   // the ack cycle: n+2 for writes and rejected accesses, n+3 for reads.
   task automatic model_step();
      int         g, done_c;
      logic       w, inr;
      logic [3:0] ma;
      logic [7:0] md;
      if ((cyc - 1) < free_at || req == 2'b00) return;
      if (req == 2'b11) g = 1 - last;
      else              g = req[1] ? 1 : 0;
      last = g;
      w    = we[g];
      ma   = (g == 1) ? a1 : a0;
      md   = (g == 1) ? d1 : d0;
      inr  = (int'(ma) < QTY);
      slot[cyc % 8].busy = 1'b1;
      if (inr) begin
         slot[cyc % 8].mem_en = 1'b1;
         slot[cyc % 8].mem_we = w;
         slot[cyc % 8].a      = ma;
         slot[cyc % 8].d      = md;
      end
      done_c = (!inr || w) ? cyc + 1 : cyc + 2;
      if (done_c == cyc + 2) slot[(cyc + 1) % 8].busy = 1'b1;
      slot[done_c % 8].busy   = 1'b1;
      slot[done_c % 8].ack[g] = 1'b1;
      slot[done_c % 8].err[g] = ~inr;
      if (inr && w)  exp_mem[ma] = md;
      if (inr && !w) begin
         slot[done_c % 8].rd_upd = 1'b1;
         slot[done_c % 8].rd_val = exp_mem[ma];
      end
      free_at = done_c + 1;
   endtask

   task automatic compare_cycle();
      slot_t s;
      if (reset) clear_model();
      s = slot[cyc % 8];
      if (s.rd_upd) exp_rdata = s.rd_val;
      chk("busy", 32'(busy), 32'(s.busy));
      chk("mem_en", 32'(mem_en), 32'(s.mem_en));
      chk("ack", 32'(ack), 32'(s.ack));
      chk("err", 32'(err), 32'(s.err));
      chk("rdata", 32'(rdata), 32'(exp_rdata));
      if (s.mem_en) begin
         chk("mem_we", 32'(mem_we), 32'(s.mem_we));
         chk("mem_addr", 32'(mem_addr), 32'(s.a));
         chk("mem_wdata", 32'(mem_wdata), 32'(s.d));
      end
      if (mem_en === 1'b1) mem_en_cnt++;
      if (ack[0] === 1'b1) ack_log.push_back(0);
      if (ack[1] === 1'b1) ack_log.push_back(1);
      slot[cyc % 8] = '{default: '0};
   endtask

   // Client side of the handshake; lat is the rising edge (counted from the one
   // before req went up) on which the client registers ack.
   task automatic txn(input int c, input logic w, input logic [3:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd, output logic er);
      int edges;
      edges = 0;
      lat   = 0;
      rd    = 8'h00;
      er    = 1'b0;
      if (c == 0) begin we0 = w; a0 = a; d0 = d; req0 = 1'b1; end
      else        begin we1 = w; a1 = a; d1 = d; req1 = 1'b1; end
      while (lat == 0) begin
         @(negedge clock);
         if (ack[c] === 1'b1) begin
            lat = edges + 1;
            rd  = rdata;
            er  = err[c];
         end else if (edges > 40) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: client %0d got no ack within %0d cycles", c, edges);
            lat = -1;
         end else begin
            @(posedge clock);
            edges++;
            #1;
         end
      end
      if (c == 0) req0 = 1'b0;
      else        req1 = 1'b0;
      @(posedge clock);
      #1;
   endtask

   initial begin
      int         lat0, lat1, cnt_before;
      logic [7:0] rd0, rd1, ram12;
      logic       er0, er1;
      checks = 0; errors = 0; cyc = 0; mem_en_cnt = 0;
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
      clear_model();
      fork
         forever begin
            @(posedge clock);
            cyc++;
            if (reset) clear_model();
            else       model_step();
         end
         forever begin
            @(negedge clock);
            compare_cycle();
         end
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
         begin
            repeat (3) @(posedge clock);
            #1;
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_mem_en", 32'(mem_en), 32'd0);
            chk("reset_ack", 32'(ack), 32'd0);
            chk("reset_rdata", 32'(rdata), 32'd0);
            reset = 1'b0;
            @(posedge clock);
            #1;

            // Preload every in-range word so all later reads have known data.
            for (int i = 0; i < QTY; i++) begin
               txn(i % 2, 1'b1, 4'(i), 8'(i * 29 + 7), lat0, rd0, er0);
               chk("preload_lat", 32'(lat0), 32'd3);
            end

            cnt_before = mem_en_cnt;
            txn(0, 1'b1, 4'd3, 8'hA5, lat0, rd0, er0);
            chk("write_lat", 32'(lat0), 32'd3);
            chk("write_err", 32'(er0), 32'd0);
            chk("write_strobes", 32'(mem_en_cnt - cnt_before), 32'd1);

            txn(1, 1'b0, 4'd3, 8'h00, lat1, rd1, er1);
            chk("read_lat", 32'(lat1), 32'd4);
            chk("read_data", 32'(rd1), 32'hA5);

            for (int k = 0; k < 2; k++) begin
               fork
                  txn(0, 1'b1, 4'd5, 8'(8'h50 + k), lat0, rd0, er0);
                  txn(1, 1'b1, 4'd6, 8'(8'h60 + k), lat1, rd1, er1);
               join
               chk("tie_c0_lat", 32'(lat0), 32'd3);
               chk("tie_c1_lat", 32'(lat1), 32'd6);
            end

            ack_log.delete();
            fork
               repeat (4) txn(0, 1'b1, 4'd7, 8'($urandom), lat0, rd0, er0);
               repeat (4) txn(1, 1'b1, 4'd8, 8'($urandom), lat1, rd1, er1);
            join
            chk("rr_ack_count", 32'(ack_log.size()), 32'd8);
            for (int i = 0; i < ack_log.size(); i++)
               chk("rr_order", 32'(ack_log[i]), 32'(i % 2));

            ram12      = ram[12];
            cnt_before = mem_en_cnt;
            txn(0, 1'b1, 4'd12, 8'h3C, lat0, rd0, er0);
            chk("oor_lat", 32'(lat0), 32'd3);
            chk("oor_err", 32'(er0), 32'd1);
            chk("oor_strobes", 32'(mem_en_cnt - cnt_before), 32'd0);
            chk("oor_ram", 32'(ram[12]), 32'(ram12));
            txn(1, 1'b0, 4'd13, 8'h00, lat1, rd1, er1);
            chk("oor_read_err", 32'(er1), 32'd1);
            chk("oor_read_rdata", 32'(rd1), 32'hA5);

            // Reset while a read sits in WAIT: the access is abandoned.
            we1 = 1'b0; a1 = 4'd3; req1 = 1'b1;
            @(posedge clock);
            @(posedge clock);
            #2;
            reset = 1'b1;
            #1;
            chk("midreset_busy", 32'(busy), 32'd0);
            chk("midreset_mem_en", 32'(mem_en), 32'd0);
            chk("midreset_ack", 32'(ack), 32'd0);
            chk("midreset_rdata", 32'(rdata), 32'd0);
            req1 = 1'b0;
            @(posedge clock);
            #1;
            reset = 1'b0;
            repeat (3) @(posedge clock);
            #1;
            txn(1, 1'b0, 4'd3, 8'h00, lat1, rd1, er1);
            chk("post_reset_lat", 32'(lat1), 32'd4);
            chk("post_reset_data", 32'(rd1), 32'hA5);

            fork
               for (int n = 0; n < 25; n++) begin
                  logic [3:0] ra;
                  repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                  ra = 4'($urandom_range(0, 15));
                  txn(0, 1'($urandom_range(0, 1)), ra, 8'($urandom), lat0, rd0, er0);
                  chk("rand_c0_err", 32'(er0), 32'(int'(ra) >= QTY));
               end
               for (int n = 0; n < 25; n++) begin
                  logic [3:0] rb;
                  repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
                  rb = 4'($urandom_range(0, 15));
                  txn(1, 1'($urandom_range(0, 1)), rb, 8'($urandom), lat1, rd1, er1);
                  chk("rand_c1_err", 32'(er1), 32'(int'(rb) >= QTY));
               end
            join

            repeat (4) @(posedge clock);
            #1;
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      join
   end

endmodule
